// File: rtl/mem_wb_stage_if.sv
// Bundle of the EX-side instruction fields, the data-memory read port and the
// writeback/status outputs of the MEM/WB stage.
interface mem_wb_stage_if;
    logic        advance;
    logic        flush;
    logic        ex_valid;
    logic        ex_regWrite;
    logic [4:0]  ex_writeReg;
    logic [31:0] ex_aluResult;
    logic [31:0] ex_pcPlus4;
    logic [15:0] ex_upperImm;
    logic [1:0]  ex_wbSource;
    logic        ex_memRead;
    logic [1:0]  ex_loadSize;
    logic        ex_loadSigned;
    logic        dmem_hit;
    logic [31:0] dmem_rdata;
    logic        dmem_ren;
    logic [31:0] dmem_addr;
    logic        stall_out;
    logic        wb_regWrite;
    logic [4:0]  wb_writeReg;
    logic [31:0] wb_writeData;
    logic        mem_timeout;

    modport master (
        output advance, flush, ex_valid, ex_regWrite, ex_writeReg, ex_aluResult,
               ex_pcPlus4, ex_upperImm, ex_wbSource, ex_memRead, ex_loadSize,
               ex_loadSigned, dmem_hit, dmem_rdata,
        input  dmem_ren, dmem_addr, stall_out, wb_regWrite, wb_writeReg,
               wb_writeData, mem_timeout
    );

    modport slave (
        input  advance, flush, ex_valid, ex_regWrite, ex_writeReg, ex_aluResult,
               ex_pcPlus4, ex_upperImm, ex_wbSource, ex_memRead, ex_loadSize,
               ex_loadSigned, dmem_hit, dmem_rdata,
        output dmem_ren, dmem_addr, stall_out, wb_regWrite, wb_writeReg,
               wb_writeData, mem_timeout
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: holds the instruction leaving EX, issues its data-memory read,
// aligns/extends the load data and produces a single-cycle register writeback.
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input logic          CLK,
    input logic          nRST,
    mem_wb_stage_if.slave bus
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DONE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        r_valid_r;
    logic        r_reg_write_r;
    logic [4:0]  r_write_reg_r;
    logic [31:0] r_alu_r;
    logic [31:0] r_pc4_r;
    logic [15:0] r_uimm_r;
    logic [1:0]  r_wb_src_r;
    logic        r_mem_read_r;
    logic [1:0]  r_load_size_r;
    logic        r_load_signed_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic        timeout_r;
    logic        wb_we_r;
    logic [4:0]  wb_reg_r;
    logic [31:0] wb_data_r;
    logic        load_pending_s;
    logic        stall_s;
    logic        capture_s;
    logic        retire_s;

    // Big-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
        logic [15:0] lane16;
        logic [7:0]  lane8;
        logic [31:0] res;
        lane16 = 16'd0;
        lane8  = 8'd0;
        res    = rdata;
        case (size)
            2'd1: begin
                lane16 = off[1] ? rdata[15:0] : rdata[31:16];
                res    = {{16{sgn & lane16[15]}}, lane16};
            end
            2'd2: begin
                case (off)
                    2'd0:    lane8 = rdata[31:24];
                    2'd1:    lane8 = rdata[23:16];
                    2'd2:    lane8 = rdata[15:8];
                    2'd3:    lane8 = rdata[7:0];
                    default: lane8 = rdata[31:24];
                endcase
                res = {{24{sgn & lane8[7]}}, lane8};
            end
            default: res = rdata;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] wb_select(input logic [1:0]  src,
                                              input logic [31:0] alu,
                                              input logic [31:0] ld,
                                              input logic [31:0] pc4,
                                              input logic [15:0] uimm);
        logic [31:0] res;
        case (src)
            2'd0:    res = alu;
            2'd1:    res = ld;
            2'd2:    res = pc4;
            2'd3:    res = {uimm, 16'd0};
            default: res = alu;
        endcase
        return res;
    endfunction

    // Stage-level handshake terms; retire marks the one edge that writes back R.
    always_comb begin
        load_pending_s = r_valid_r && r_mem_read_r && (state_r == ST_IDLE);
        stall_s        = load_pending_s && !bus.dmem_hit;
        capture_s      = bus.advance && !stall_s && !bus.flush;
        retire_s       = r_valid_r && (state_r == ST_IDLE) && !bus.flush &&
                         (!r_mem_read_r || bus.dmem_hit);
    end

    assign bus.dmem_ren     = load_pending_s;
    assign bus.dmem_addr    = {r_alu_r[31:2], 2'b00};
    assign bus.stall_out    = stall_s;
    assign bus.wb_regWrite  = wb_we_r;
    assign bus.wb_writeReg  = wb_reg_r;
    assign bus.wb_writeData = wb_data_r;
    assign bus.mem_timeout  = timeout_r;

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // DONE blocks a second writeback/request while R is held by an external stall.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (retire_s && !capture_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (bus.flush || capture_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Stage register R: flush beats capture, otherwise hold.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid_r       <= 1'b0;
            r_reg_write_r   <= 1'b0;
            r_write_reg_r   <= 5'd0;
            r_alu_r         <= 32'd0;
            r_pc4_r         <= 32'd0;
            r_uimm_r        <= 16'd0;
            r_wb_src_r      <= 2'd0;
            r_mem_read_r    <= 1'b0;
            r_load_size_r   <= 2'd0;
            r_load_signed_r <= 1'b0;
        end else if (bus.flush) begin
            r_valid_r <= 1'b0;
        end else if (capture_s) begin
            r_valid_r       <= bus.ex_valid;
            r_reg_write_r   <= bus.ex_regWrite;
            r_write_reg_r   <= bus.ex_writeReg;
            r_alu_r         <= bus.ex_aluResult;
            r_pc4_r         <= bus.ex_pcPlus4;
            r_uimm_r        <= bus.ex_upperImm;
            r_wb_src_r      <= bus.ex_wbSource;
            r_mem_read_r    <= bus.ex_memRead;
            r_load_size_r   <= bus.ex_loadSize;
            r_load_signed_r <= bus.ex_loadSigned;
        end
    end

    // Wait counter next value: saturating count of unanswered request cycles.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (bus.flush || capture_s || (load_pending_s && bus.dmem_hit)) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (stall_s && (cnt_r < CNT_MAX)) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Wait counter and sticky timeout flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r     <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            timeout_r <= timeout_r | (cnt_nxt_s == CNT_MAX);
        end
    end

    // Registered writeback port; the enable is a one-cycle pulse per instruction.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_we_r   <= 1'b0;
            wb_reg_r  <= 5'd0;
            wb_data_r <= 32'd0;
        end else begin
            wb_we_r <= retire_s && r_reg_write_r && (r_write_reg_r != 5'd0);
            if (retire_s) begin
                wb_reg_r  <= r_write_reg_r;
                wb_data_r <= wb_select(r_wb_src_r, r_alu_r,
                                       align_load(bus.dmem_rdata, r_alu_r[1:0],
                                                  r_load_size_r, r_load_signed_r),
                                       r_pc4_r, r_uimm_r);
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases, randomized instruction
// stream against a spec-level reference model, flush, timeout and reset checks.
module tb_mem_wb_stage;

    logic CLK;
    logic nRST;
    int   chk_cnt;
    int   pass_cnt;
    int   err_cnt;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference: pick the addressed big-endian lane by shifting, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [1:0] size, input logic sgn);
        int unsigned off;
        logic [31:0] v;
        off = addr[1:0];
        if (size == 2'd1) begin
            v = (rdata >> (off >= 2 ? 0 : 16)) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else if (size == 2'd2) begin
            v = (rdata >> (8 * (3 - off))) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wb(input logic [1:0] src, input logic [31:0] alu,
                                             input logic [31:0] ld, input logic [31:0] pc,
                                             input logic [15:0] ui);
        if (src == 2'd0) return alu;
        if (src == 2'd1) return ld;
        if (src == 2'd2) return pc;
        return {ui, 16'h0000};
    endfunction

    task automatic drive_idle();
        bus.advance = 1'b0; bus.flush = 1'b0; bus.ex_valid = 1'b0;
        bus.ex_regWrite = 1'b0; bus.ex_writeReg = 5'd0; bus.ex_aluResult = 32'd0;
        bus.ex_pcPlus4 = 32'd0; bus.ex_upperImm = 16'd0; bus.ex_wbSource = 2'd0;
        bus.ex_memRead = 1'b0; bus.ex_loadSize = 2'd0; bus.ex_loadSigned = 1'b0;
        bus.dmem_hit = 1'b0; bus.dmem_rdata = 32'd0;
    endtask

    // Present one instruction for a single capture edge, leave advance low afterwards.
    task automatic capture(input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] pc, input logic [15:0] ui, input logic [1:0] src,
                           input logic [1:0] lsz, input logic lsg);
        @(negedge CLK);
        bus.advance = 1'b1; bus.ex_valid = 1'b1; bus.ex_regWrite = rw; bus.ex_writeReg = rd;
        bus.ex_aluResult = alu; bus.ex_pcPlus4 = pc; bus.ex_upperImm = ui; bus.ex_wbSource = src;
        bus.ex_memRead = (src == 2'd1); bus.ex_loadSize = lsz; bus.ex_loadSigned = lsg;
        @(posedge CLK);
        #1;
        bus.advance = 1'b0; bus.ex_valid = 1'b0;
    endtask

    task automatic run_instr(input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                             input logic [31:0] pc, input logic [15:0] ui, input logic [1:0] src,
                             input logic [1:0] lsz, input logic lsg, input logic [31:0] rdata,
                             input int lat);
        logic [31:0] exp_data;
        logic        exp_we;
        capture(rw, rd, alu, pc, ui, src, lsz, lsg);
        if (src == 2'd1) begin
            for (int c = 0; c <= lat; c++) begin
                if (c == lat) begin
                    bus.dmem_hit = 1'b1;
                    bus.dmem_rdata = rdata;
                end
                @(negedge CLK);
                check_val("ren_wait", 32'(bus.dmem_ren), 32'd1);
                check_val("addr", bus.dmem_addr, {alu[31:2], 2'b00});
                check_val("stall", 32'(bus.stall_out), (c < lat) ? 32'd1 : 32'd0);
                check_val("we_wait", 32'(bus.wb_regWrite), 32'd0);
                @(posedge CLK);
                #1;
            end
            bus.dmem_hit = 1'b0;
            bus.dmem_rdata = $urandom;
        end else begin
            @(negedge CLK);
            check_val("ren_nonload", 32'(bus.dmem_ren), 32'd0);
            check_val("stall_nonload", 32'(bus.stall_out), 32'd0);
            @(posedge CLK);
            #1;
        end
        exp_we   = rw && (rd != 5'd0);
        exp_data = model_wb(src, alu, model_load(rdata, alu, lsz, lsg), pc, ui);
        @(negedge CLK);
        check_val("wb_we", 32'(bus.wb_regWrite), 32'(exp_we));
        if (exp_we) begin
            check_val("wb_reg", 32'(bus.wb_writeReg), 32'(rd));
            check_val("wb_data", bus.wb_writeData, exp_data);
        end
        check_val("ren_after", 32'(bus.dmem_ren), 32'd0);
        @(negedge CLK);
        check_val("wb_pulse", 32'(bus.wb_regWrite), 32'd0);
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0; err_cnt = 0;
        drive_idle();
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_ren", 32'(bus.dmem_ren), 32'd0);
        check_val("rst_stall", 32'(bus.stall_out), 32'd0);
        check_val("rst_we", 32'(bus.wb_regWrite), 32'd0);
        check_val("rst_data", bus.wb_writeData, 32'd0);
        check_val("rst_tmo", 32'(bus.mem_timeout), 32'd0);
        nRST = 1'b1;

        // Directed cases.
        run_instr(1'b1, 5'd5, 32'h0000_1234, 32'h0, 16'h0, 2'd0, 2'd0, 1'b0, 32'h0, 0);
        run_instr(1'b1, 5'd6, 32'h0000_0100, 32'h0, 16'h0, 2'd1, 2'd2, 1'b1, 32'h80AB_CDEF, 3);
        run_instr(1'b1, 5'd7, 32'h0000_0103, 32'h0, 16'h0, 2'd1, 2'd2, 1'b0, 32'h80AB_CDEF, 1);
        run_instr(1'b1, 5'd8, 32'h0000_0202, 32'h0, 16'h0, 2'd1, 2'd1, 1'b1, 32'h1234_F00D, 2);
        run_instr(1'b1, 5'd9, 32'h0000_0200, 32'h0, 16'h0, 2'd1, 2'd1, 1'b0, 32'h1234_F00D, 0);
        run_instr(1'b1, 5'd10, 32'h0, 32'h0, 16'hBEEF, 2'd3, 2'd0, 1'b0, 32'h0, 0);
        run_instr(1'b1, 5'd31, 32'h0, 32'h0000_0040, 16'h0, 2'd2, 2'd0, 1'b0, 32'h0, 0);
        run_instr(1'b1, 5'd0, 32'h0000_5555, 32'h0, 16'h0, 2'd0, 2'd0, 1'b0, 32'h0, 0);
        run_instr(1'b1, 5'd3, 32'h0000_0011, 32'h0, 16'h0, 2'd1, 2'd3, 1'b1, 32'hCAFE_F00D, 2);

        // Randomized instruction stream; latency kept below the timeout.
        for (int i = 0; i < 40; i++) begin
            logic [4:0] rd_v;
            rd_v = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) rd_v = 5'd0;
            run_instr(1'($urandom_range(0, 1)), rd_v, $urandom, $urandom, 16'($urandom),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
        end
        check_val("tmo_clear", 32'(bus.mem_timeout), 32'd0);

        // Flush on the second wait cycle, then a late hit must be ignored.
        capture(1'b1, 5'd12, 32'h0000_0400, 32'h0, 16'h0, 2'd1, 2'd0, 1'b0);
        @(negedge CLK);
        check_val("fl_ren1", 32'(bus.dmem_ren), 32'd1);
        @(posedge CLK);
        #1;
        bus.flush = 1'b1;
        @(negedge CLK);
        check_val("fl_ren2", 32'(bus.dmem_ren), 32'd1);
        @(posedge CLK);
        #1;
        bus.flush = 1'b0;
        bus.dmem_hit = 1'b1;
        bus.dmem_rdata = 32'h1111_2222;
        @(negedge CLK);
        check_val("fl_ren_drop", 32'(bus.dmem_ren), 32'd0);
        check_val("fl_stall", 32'(bus.stall_out), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check_val("fl_nowrite", 32'(bus.wb_regWrite), 32'd0);
        end
        bus.dmem_hit = 1'b0;

        // Timeout: no hit ever arrives.
        capture(1'b1, 5'd13, 32'h0000_0800, 32'h0, 16'h0, 2'd1, 2'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            check_val("tmo_flag", 32'(bus.mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
            check_val("tmo_stall", 32'(bus.stall_out), 32'd1);
        end
        #1;
        bus.flush = 1'b1;
        @(posedge CLK);
        #1;
        bus.flush = 1'b0;
        @(negedge CLK);
        check_val("tmo_sticky", 32'(bus.mem_timeout), 32'd1);
        check_val("tmo_ren", 32'(bus.dmem_ren), 32'd0);

        // Reset in the middle of a pending load.
        capture(1'b1, 5'd14, 32'h0000_0C04, 32'h0, 16'h0, 2'd1, 2'd0, 1'b0);
        @(negedge CLK);
        check_val("rml_ren", 32'(bus.dmem_ren), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_val("rml_ren0", 32'(bus.dmem_ren), 32'd0);
        check_val("rml_addr0", bus.dmem_addr, 32'd0);
        check_val("rml_stall0", 32'(bus.stall_out), 32'd0);
        check_val("rml_we0", 32'(bus.wb_regWrite), 32'd0);
        check_val("rml_reg0", 32'(bus.wb_writeReg), 32'd0);
        check_val("rml_data0", bus.wb_writeData, 32'd0);
        check_val("rml_tmo0", 32'(bus.mem_timeout), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        bus.dmem_hit = 1'b1;
        bus.dmem_rdata = 32'h3333_4444;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check_val("rml_nowrite", 32'(bus.wb_regWrite), 32'd0);
            check_val("rml_noren", 32'(bus.dmem_ren), 32'd0);
        end
        bus.dmem_hit = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
